// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one Avalon-style memory port between fetch and data.
// Define SUBWORD_RMW_EN to turn byte/half stores into read-modify-write.
module mem_port_arbiter #(
  parameter int unsigned DATA_PRIORITY = 1,
  parameter int unsigned MAX_WAIT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        stall,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest
);

  typedef enum logic [2:0] {
    IDLE, IF_RD, D_RD, D_WR, RMW_RD, RMW_WR, RESP
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ptr_q, ptr_d;
  logic        own_d_q, own_d_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [3:0]  lane_q, lane_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        d_half, d_word, d_mis;
  logic [3:0]  d_be;
  logic [31:0] d_rep;
  logic [31:0] lane_mask, merged;
  logic        go_d, go_if, timeout, rd_st, wr_st;
  logic        unused_ok;

  assign unused_ok = ^if_addr[1:0];

  always_comb begin
    d_half = d_size == 2'b01;
    d_word = d_size[1];
    d_mis  = (d_half & d_addr[0])
           | (d_word & (d_addr[1:0] != 2'b00));
    d_be   = 4'h0;
    d_rep  = '0;
    unique case (1'b1)
      d_word: begin
        d_be  = 4'hF;
        d_rep = d_wdata;
      end
      d_half: begin
        d_be  = d_addr[1] ? 4'b1100 : 4'b0011;
        d_rep = {2{d_wdata[15:0]}};
      end
      default: begin
        d_be  = 4'b0001 << d_addr[1:0];
        d_rep = {4{d_wdata[7:0]}};
      end
    endcase
  end

  assign lane_mask = {{8{lane_q[3]}}, {8{lane_q[2]}},
                      {8{lane_q[1]}}, {8{lane_q[0]}}};
  assign merged    = (mem_readdata & ~lane_mask)
                   | (wdata_q & lane_mask);

  // ptr_q=1 means D wins the next tie when alternating
  assign go_d  = d_req & (~if_req | (DATA_PRIORITY != 0) | ptr_q);
  assign go_if = if_req & ~go_d;

  assign timeout = cnt_q == 8'(MAX_WAIT);
  assign rd_st   = state_q inside {IF_RD, D_RD, RMW_RD};
  assign wr_st   = state_q inside {D_WR, RMW_WR};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    own_d_d = own_d_q;
    err_d   = err_q;
    addr_d  = addr_q;
    be_d    = be_q;
    lane_d  = lane_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (go_d) begin
          own_d_d = 1'b1;
          ptr_d   = 1'b0;
          err_d   = 1'b0;
          addr_d  = {d_addr[31:2], 2'b00};
          if (d_mis) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else if (d_we) begin
            wdata_d = d_rep;
            lane_d  = d_be;
            be_d    = d_be;
            state_d = D_WR;
`ifdef SUBWORD_RMW_EN
            if (d_be != 4'hF) begin
              be_d    = 4'hF;
              state_d = RMW_RD;
            end
`endif
          end else begin
            be_d    = 4'hF;
            state_d = D_RD;
          end
        end else if (go_if) begin
          own_d_d = 1'b0;
          ptr_d   = 1'b1;
          err_d   = 1'b0;
          addr_d  = {if_addr[31:2], 2'b00};
          be_d    = 4'hF;
          state_d = IF_RD;
        end
      end
      IF_RD, D_RD, D_WR, RMW_RD, RMW_WR: begin
        if (timeout) begin
          err_d   = own_d_q;
          state_d = RESP;
          if (state_q == IF_RD) rdata_d = '0;
        end else if (!mem_waitrequest) begin
          state_d = RESP;
          if (state_q inside {IF_RD, D_RD}) rdata_d = mem_readdata;
          if (state_q == RMW_RD) begin
            wdata_d = merged;
            cnt_d   = '0;
            state_d = RMW_WR;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      own_d_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'hF;
      lane_q  <= 4'hF;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      own_d_q <= own_d_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      lane_q  <= lane_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_read       = rd_st & ~timeout;
  assign mem_write      = wr_st & ~timeout;
  assign mem_address    = addr_q;
  assign mem_byteenable = be_q;
  assign mem_writedata  = wdata_q;

  assign if_valid = (state_q == RESP) & ~own_d_q;
  assign d_valid  = (state_q == RESP) & own_d_q;
  assign d_err    = d_valid & err_q;
  assign if_rdata = rdata_q;
  assign d_rdata  = rdata_q;
  assign stall    = (if_req | d_req) & ~(if_valid | d_valid);

endmodule
